// File: rtl/fir_cfg_pkg.sv
// Shared constants and types for the FIR coefficient configuration path.
package fir_cfg_pkg;
  localparam int TAPS = 16;
  localparam int DW   = 12;
  localparam int AW   = 8;
  localparam int TW   = (TAPS > 1) ? $clog2(TAPS) : 1;

  localparam logic [AW-1:0] COMMIT_ADDR = 8'hFF;
  localparam logic [AW-1:0] CLEAR_ADDR  = 8'hFD;
  localparam logic [AW-1:0] STATUS_ADDR = 8'hFE;

  typedef enum logic [1:0] {IDLE, HALT, LOAD, RELEASE} cfg_state_t;
  typedef logic [DW-1:0] coef_t;

  function automatic logic is_tap(input logic [AW-1:0] a);
    return a < AW'(TAPS);
  endfunction
endpackage

// File: rtl/fir_coef_bank.sv
// Shadow coefficient register file: one write port, a registered readback
// port and a combinational port feeding the filter load stream.
module fir_coef_bank
  import fir_cfg_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [TW-1:0] i_waddr,
  input  coef_t         i_wdata,
  input  logic [AW-1:0] i_raddr,
  output coef_t         o_rdata,
  input  logic [TW-1:0] i_laddr,
  output coef_t         o_ldata
);
  logic [TAPS-1:0][DW-1:0] r_mem;
  coef_t                   r_rdata;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mem   <= '0;
      r_rdata <= '0;
    end else begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      // read sees the pre-write contents on a same-cycle collision
      r_rdata <= is_tap(i_raddr) ? r_mem[i_raddr[TW-1:0]] : '0;
    end
  end

  assign o_rdata = r_rdata;
  assign o_ldata = r_mem[i_laddr];
endmodule

// File: rtl/fir_coef_loader.sv
// Commit controller: halts the filter, streams every shadow tap into it one
// per cycle, then releases it, so the filter sees an atomic coefficient swap.
module fir_coef_loader
  import fir_cfg_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_spi_load,
  input  logic [AW-1:0] i_spi_addr,
  input  logic [DW-1:0] i_spi_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data,
  output logic          o_fir_hlt,
  output logic [AW-1:0] o_fir_waddr,
  output logic [DW-1:0] o_fir_wdata,
  output logic          o_fir_load,
  output logic          o_busy,
  output logic          o_dirty,
  output logic          o_ovr
);
  localparam int SW = $clog2(SETTLE + 1);

  cfg_state_t    r_state, w_state_nx;
  logic [SW-1:0] r_scnt, w_scnt_nx;
  logic [TW-1:0] r_tcnt, w_tcnt_nx;
  logic          r_dirty, r_ovr, r_is_stat;
  logic [2:0]    r_stat;
  logic          w_busy, w_is_tap, w_is_commit, w_wr, w_commit, w_drop, w_clear;
  coef_t         w_rdata, w_ldata;

  assign w_busy      = (r_state != IDLE);
  assign w_is_tap    = is_tap(i_spi_addr);
  assign w_is_commit = (i_spi_addr == COMMIT_ADDR);
  assign w_wr        = i_spi_load && !w_busy && w_is_tap;
  assign w_commit    = i_spi_load && !w_busy && w_is_commit;
  assign w_drop      = i_spi_load &&  w_busy && (w_is_tap || w_is_commit);
  assign w_clear     = i_spi_load && (i_spi_addr == CLEAR_ADDR);

  fir_coef_bank u_bank (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_wr),
    .i_waddr (i_spi_addr[TW-1:0]),
    .i_wdata (i_spi_data),
    .i_raddr (i_rd_addr),
    .o_rdata (w_rdata),
    .i_laddr (r_tcnt),
    .o_ldata (w_ldata)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_scnt  <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_scnt  <= w_scnt_nx;
      r_tcnt  <= w_tcnt_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_scnt_nx   = r_scnt;
    w_tcnt_nx   = r_tcnt;
    o_fir_hlt   = 1'b0;
    o_fir_load  = 1'b0;
    o_fir_waddr = '0;
    o_fir_wdata = '0;
    case (r_state)
      IDLE: begin
        if (w_commit) begin
          w_state_nx = HALT;
          w_scnt_nx  = '0;
          w_tcnt_nx  = '0;
        end
      end
      HALT: begin
        o_fir_hlt = 1'b1;
        if (r_scnt == SW'(SETTLE - 1)) w_state_nx = LOAD;
        else                           w_scnt_nx  = r_scnt + 1'b1;
      end
      LOAD: begin
        o_fir_hlt   = 1'b1;
        o_fir_load  = 1'b1;
        o_fir_waddr = AW'(r_tcnt);
        o_fir_wdata = w_ldata;
        if (r_tcnt == TW'(TAPS - 1)) w_state_nx = RELEASE;
        else                         w_tcnt_nx  = r_tcnt + 1'b1;
      end
      RELEASE: begin
        o_fir_hlt  = 1'b1;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_dirty   <= 1'b0;
      r_ovr     <= 1'b0;
      r_stat    <= '0;
      r_is_stat <= 1'b0;
    end else begin
      if (r_state == RELEASE) r_dirty <= 1'b0;
      else if (w_wr)          r_dirty <= 1'b1;
      // a dropped access outranks a clear arriving on the same edge
      if (w_drop)       r_ovr <= 1'b1;
      else if (w_clear) r_ovr <= 1'b0;
      r_stat    <= {r_ovr, r_dirty, w_busy};
      r_is_stat <= (i_rd_addr == STATUS_ADDR);
    end
  end

  assign o_rd_data = r_is_stat ? {{(DW-3){1'b0}}, r_stat} : w_rdata;
  assign o_busy    = w_busy;
  assign o_dirty   = r_dirty;
  assign o_ovr     = r_ovr;
endmodule

// File: tb/tb_fir_coef_loader.sv
// Scoreboard bench: the driver advances a transaction-level model and queues
// expectations; a negedge monitor pops and compares against the DUT.
module tb_fir_coef_loader;
  import fir_cfg_pkg::*;
  localparam int SETTLE = 2;
  localparam int BUSY_LEN = SETTLE + TAPS + 1;

  logic          clk, rst_n, spi_load;
  logic [AW-1:0] spi_addr, rd_addr, fir_waddr;
  logic [DW-1:0] spi_data, rd_data, fir_wdata;
  logic          fir_hlt, fir_load, busy, dirty, ovr;

  fir_coef_loader #(.SETTLE(SETTLE)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_spi_load(spi_load), .i_spi_addr(spi_addr),
    .i_spi_data(spi_data), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_fir_hlt(fir_hlt), .o_fir_waddr(fir_waddr), .o_fir_wdata(fir_wdata),
    .o_fir_load(fir_load), .o_busy(busy), .o_dirty(dirty), .o_ovr(ovr)
  );

  typedef struct { int cyc; int a; int d; } ld_t;
  typedef struct { int cyc; bit b; bit dt; bit o; } st_t;
  typedef struct { int cyc; int v; } rd_t;

  ld_t ld_q[$];
  st_t st_q[$];
  rd_t rd_q[$];

  int total = 0, bad = 0, ecnt = 0;
  bit mvalid = 0;

  // reference state: shadow contents, flags, and cycles left in the commit window
  int m_shadow[TAPS];
  bit m_dirty, m_ovr;
  int m_bleft;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, ecnt, act, exp);
    end
  endtask

  task automatic model_edge();
    int  a, rv;
    bit  bnow;
    rd_t r;
    st_t s;
    ld_t l;
    if (!rst_n) begin
      foreach (m_shadow[i]) m_shadow[i] = 0;
      m_dirty = 0; m_ovr = 0; m_bleft = 0;
      ld_q.delete();
      r.cyc = ecnt; r.v = 0; rd_q.push_back(r);
      s.cyc = ecnt; s.b = 0; s.dt = 0; s.o = 0; st_q.push_back(s);
      mvalid = 1;
      return;
    end
    if (!mvalid) return;
    bnow = (m_bleft > 0);
    a = int'(rd_addr);
    if (a < TAPS)                 rv = m_shadow[a];
    else if (rd_addr == STATUS_ADDR) rv = {29'd0, m_ovr, m_dirty, bnow};
    else                          rv = 0;
    r.cyc = ecnt; r.v = rv; rd_q.push_back(r);
    if (bnow) begin
      m_bleft--;
      if (m_bleft == 0) m_dirty = 0;
    end
    if (spi_load) begin
      a = int'(spi_addr);
      if (spi_addr == CLEAR_ADDR) m_ovr = 0;
      if (bnow) begin
        if (a < TAPS || spi_addr == COMMIT_ADDR) m_ovr = 1;
      end else if (a < TAPS) begin
        m_shadow[a] = int'(spi_data);
        m_dirty = 1;
      end else if (spi_addr == COMMIT_ADDR) begin
        m_bleft = BUSY_LEN;
        for (int i = 0; i < TAPS; i++) begin
          l.cyc = ecnt + SETTLE + i; l.a = i; l.d = m_shadow[i];
          ld_q.push_back(l);
        end
      end
    end
    s.cyc = ecnt; s.b = (m_bleft > 0); s.dt = m_dirty; s.o = m_ovr;
    st_q.push_back(s);
  endtask

  task automatic tick();
    @(posedge clk);
    ecnt++;
    model_edge();
    #1;
  endtask

  task automatic spi_wr(input int a, input int d);
    spi_load = 1; spi_addr = AW'(a); spi_data = DW'(d);
    tick();
    spi_load = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      if (st_q.size() == 0 || st_q[0].cyc != ecnt) begin
        chk("status_sync", st_q.size(), 1);
      end else begin
        st_t s;
        s = st_q.pop_front();
        chk("busy", int'(busy), int'(s.b));
        chk("fir_hlt", int'(fir_hlt), int'(s.b));
        chk("dirty", int'(dirty), int'(s.dt));
        chk("ovr", int'(ovr), int'(s.o));
      end
      if (rd_q.size() == 0 || rd_q[0].cyc != ecnt) begin
        chk("rd_sync", rd_q.size(), 1);
      end else begin
        rd_t r;
        r = rd_q.pop_front();
        chk("rd_data", int'(rd_data), r.v);
      end
      while (ld_q.size() > 0 && ld_q[0].cyc < ecnt) begin
        ld_t l;
        l = ld_q.pop_front();
        chk("fir_load_missing", 0, 1);
      end
      if (fir_load) begin
        if (ld_q.size() == 0 || ld_q[0].cyc != ecnt) begin
          chk("fir_load_unexpected", 1, 0);
        end else begin
          ld_t l;
          l = ld_q.pop_front();
          chk("fir_waddr", int'(fir_waddr), l.a);
          chk("fir_wdata", int'(fir_wdata), l.d);
        end
      end else begin
        chk("fir_load_absent", int'(ld_q.size() > 0 && ld_q[0].cyc == ecnt), 0);
        chk("fir_bus_idle", int'(fir_waddr) + int'(fir_wdata), 0);
      end
    end
  end

  initial begin
    int c;
    rst_n = 0; spi_load = 0; spi_addr = '0; spi_data = '0; rd_addr = '0;
    idle(3);
    rst_n = 1;
    rd_addr = STATUS_ADDR; tick();
    rd_addr = 8'd3;        tick();

    spi_wr(5, 12'h0A5);
    rd_addr = 8'd5; tick();
    rd_addr = STATUS_ADDR; tick();

    for (int i = 0; i < TAPS; i++) spi_wr(i, i + 1);
    spi_wr(COMMIT_ADDR, 0);
    idle(BUSY_LEN + 3);

    spi_wr(COMMIT_ADDR, 0);
    idle(4);
    spi_wr(2, 12'h777);
    rd_addr = 8'd2;
    idle(BUSY_LEN);
    rd_addr = STATUS_ADDR; tick();
    spi_wr(CLEAR_ADDR, 0);
    tick();

    spi_wr(COMMIT_ADDR, 0);
    idle(SETTLE + 4);
    rst_n = 0; tick();
    rst_n = 1;
    rd_addr = 8'd7; tick();

    spi_wr(COMMIT_ADDR, 0);
    idle(2);
    spi_wr(COMMIT_ADDR, 0);
    rd_addr = STATUS_ADDR;
    idle(BUSY_LEN + 2);

    for (int n = 0; n < 1500; n++) begin
      c = $urandom_range(0, 99);
      case ($urandom_range(0, 3))
        0: rd_addr = STATUS_ADDR;
        1: rd_addr = AW'($urandom_range(0, 255));
        default: rd_addr = AW'($urandom_range(0, TAPS - 1));
      endcase
      if (c == 0) begin
        rst_n = 0; tick(); rst_n = 1;
      end else if (c < 30) begin
        spi_wr($urandom_range(0, TAPS - 1), $urandom_range(0, (1 << DW) - 1));
      end else if (c < 33) begin
        spi_wr(COMMIT_ADDR, $urandom_range(0, 4095));
      end else if (c < 36) begin
        spi_wr(CLEAR_ADDR, 0);
      end else if (c < 40) begin
        spi_wr($urandom_range(0, 255), $urandom_range(0, 4095));
      end else begin
        tick();
      end
    end
    idle(BUSY_LEN + 4);
    chk("load_queue_drained", ld_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
